// File: rtl/pred_unit_arbiter.sv
// rtl/pred_unit_arbiter.sv - round-robin arbiter sharing one combinational bit-predicate unit
module pred_unit_arbiter #(
  parameter int NREQ   = 4,
  parameter int W      = 8,
  parameter int SETTLE = 1,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [W-1:0]      pred_in,
  input  logic              pred_out,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_data,
  input  logic              rsp_ready,
  output logic              busy,
  input  logic              cnt_clr,
  output logic [15:0]       hit_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]     state;
  logic [IDW-1:0] ptr;
  logic [3:0]     cnt;
  logic           any_req;
  logic [IDW-1:0] gnt_idx;
  logic [W-1:0]   gnt_data;
  logic           rsp_fire;

  // Search upward from ptr+1; the sum is one bit wider so the wrap needs no modulo.
  always_comb begin
    logic [IDW:0] cand;
    any_req = 1'b0;
    gnt_idx = ptr;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ))
        cand = cand - (IDW+1)'(NREQ);
      if (!any_req && req_valid[cand[IDW-1:0]]) begin
        any_req = 1'b1;
        gnt_idx = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NREQ; i++)
      if (IDW'(i) == gnt_idx)
        gnt_data = req_data[i*W +: W];
  end

  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && any_req)
      req_ready[gnt_idx] = 1'b1;
  end

  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);
  assign rsp_fire  = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ptr      <= IDW'(NREQ - 1);
      cnt      <= '0;
      pred_in  <= '0;
      rsp_id   <= '0;
      rsp_data <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            pred_in <= gnt_data;
            rsp_id  <= gnt_idx;
            ptr     <= gnt_idx;
            cnt     <= 4'(SETTLE - 1);
            state   <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt == 4'd0) begin
            rsp_data <= pred_out;
            state    <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_fire)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Clear wins over a simultaneous hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      hit_count <= '0;
    else if (cnt_clr)
      hit_count <= '0;
    else if (rsp_fire && rsp_data && hit_count != 16'hFFFF)
      hit_count <= hit_count + 16'd1;
  end

endmodule

// File: tb/tb_pred_unit_arbiter.sv
// tb/tb_pred_unit_arbiter.sv - bench for pred_unit_arbiter (SETTLE=1 and SETTLE=4 instances)
module tb_pred_unit_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*W-1:0] req_data = '0;
  logic rsp_ready = 1'b1;
  logic cnt_clr = 1'b0;

  logic [1:0][NREQ-1:0] req_ready;
  logic [1:0][W-1:0]    pred_in;
  logic [1:0]           pred_out, rsp_valid, rsp_data, busy;
  logic [1:0][1:0]      rsp_id;
  logic [1:0][15:0]     hit_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int ST = (g == 0) ? 1 : 4;

    assign pred_out[g] = (pred_in[g] == 8'h5A);

    pred_unit_arbiter #(.NREQ(NREQ), .W(W), .SETTLE(ST)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready[g]),
      .pred_in(pred_in[g]), .pred_out(pred_out[g]),
      .rsp_valid(rsp_valid[g]), .rsp_id(rsp_id[g]), .rsp_data(rsp_data[g]),
      .rsp_ready(rsp_ready), .busy(busy[g]),
      .cnt_clr(cnt_clr), .hit_count(hit_count[g])
    );

    // Transaction-level reference: edge number of acceptance decides when the result is due.
    bit          m_busy;
    int          m_e, m_acc, m_last;
    logic [1:0]  m_id;
    logic [7:0]  m_pred;
    bit          m_data;
    logic [15:0] m_hits;

    always @(posedge clk or negedge rst_n) begin
      bit was_valid;
      int p;
      if (!rst_n) begin
        m_busy = 0; m_e = 0; m_acc = 0; m_last = NREQ - 1;
        m_id = 0; m_pred = 0; m_data = 0; m_hits = 0;
      end else begin
        was_valid = m_busy && (m_e >= m_acc + ST);
        m_e++;
        p = pick(req_valid, m_last);
        if (cnt_clr) m_hits = 0;
        if (was_valid && rsp_ready) begin
          m_busy = 0;
          if (!cnt_clr && m_data && m_hits != 16'hFFFF) m_hits++;
        end else if (!m_busy && p >= 0) begin
          m_busy = 1; m_acc = m_e; m_last = p; m_id = 2'(p);
          m_pred = req_data[p*W +: W];
          m_data = (m_pred == 8'h5A);
        end
      end
    end

    always @(negedge clk) begin
      logic [NREQ-1:0] exp_rr;
      bit exp_rv;
      int p;
      p = pick(req_valid, m_last);
      exp_rr = (!m_busy && p >= 0) ? NREQ'(1 << p) : '0;
      exp_rv = m_busy && (m_e >= m_acc + ST);
      chk($sformatf("i%0d req_ready", g), 32'(req_ready[g]), 32'(exp_rr));
      chk($sformatf("i%0d rsp_valid", g), 32'(rsp_valid[g]), 32'(exp_rv));
      chk($sformatf("i%0d busy", g), 32'(busy[g]), 32'(m_busy));
      chk($sformatf("i%0d pred_in", g), 32'(pred_in[g]), 32'(m_pred));
      chk($sformatf("i%0d rsp_id", g), 32'(rsp_id[g]), 32'(m_id));
      chk($sformatf("i%0d hit_count", g), 32'(hit_count[g]), 32'(m_hits));
      if (exp_rv)
        chk($sformatf("i%0d rsp_data", g), 32'(rsp_data[g]), 32'(m_data));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    cnt_clr   = 1'b0;
    repeat (12) step();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int gq[$];
    int cq[$];
    logic held_id, held_data;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst req_ready", 32'(req_ready[0]), 32'h0);
    chk("rst busy", 32'(busy[0]), 32'h0);
    chk("rst rsp_valid", 32'(rsp_valid[0]), 32'h0);
    chk("rst pred_in", 32'(pred_in[0]), 32'h0);
    chk("rst hit_count", 32'(hit_count[0]), 32'h0);
    step();
    rst_n = 1'b1;

    // Single request from requester 2
    step();
    req_valid = 4'b0100;
    req_data  = {8'h11, 8'h5A, 8'h22, 8'h33};
    @(negedge clk);
    chk("single req_ready", 32'(req_ready[0]), 32'h4);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("single accepted ready", 32'(req_ready[0]), 32'h0);
    chk("single busy", 32'(busy[0]), 32'h1);
    chk("single pred_in", 32'(pred_in[0]), 32'h5A);
    chk("single early rsp_valid", 32'(rsp_valid[0]), 32'h0);
    step();
    @(negedge clk);
    chk("single rsp_valid", 32'(rsp_valid[0]), 32'h1);
    chk("single rsp_id", 32'(rsp_id[0]), 32'h2);
    chk("single rsp_data", 32'(rsp_data[0]), 32'h1);
    step();
    @(negedge clk);
    chk("single done", 32'(rsp_valid[0]), 32'h0);
    chk("single hit_count", 32'(hit_count[0]), 32'h1);
    drain();

    // Round-robin with all requesters active
    pulse_reset();
    req_valid = 4'hF;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (req_ready[0] != '0) begin
        gq.push_back($clog2(req_ready[0]));
        cq.push_back(c);
      end
      step();
      req_data = {$urandom, $urandom};
    end
    chk("rr grant count", 32'(gq.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < gq.size()) begin
        chk($sformatf("rr grant %0d", i), 32'(gq[i]), 32'(i % NREQ));
        chk($sformatf("rr cycle %0d", i), 32'(cq[i]), 32'(3 * i));
      end
    drain();

    // Backpressure
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    req_data  = {$urandom, $urandom};
    n = 0;
    @(negedge clk);
    while (!rsp_valid[0] && n < 10) begin @(negedge clk); n++; end
    chk("bp reached RESP", 32'(rsp_valid[0]), 32'h1);
    held_id = rsp_id[0][0];
    held_data = rsp_data[0];
    step();
    req_valid = 4'b1011;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp rsp_valid held", 32'(rsp_valid[0]), 32'h1);
      chk("bp rsp_id held", 32'(rsp_id[0]), 32'h1);
      chk("bp rsp_data held", 32'(rsp_data[0]), 32'(held_data));
      chk("bp no req_ready", 32'(req_ready[0]), 32'h0);
      chk("bp busy", 32'(busy[0]), 32'h1);
      step();
    end
    rsp_ready = 1'b1;
    step();
    @(negedge clk);
    chk("bp completes", 32'(rsp_valid[0]), 32'h0);
    chk("bp idle", 32'(busy[0]), 32'h0);
    chk("bp id bit", 32'(held_id), 32'h1);
    drain();

    // SETTLE=4 instance: operand change after accept must not reach pred_in
    req_valid = 4'b0001;
    req_data  = {24'h0, 8'h5A};
    step();
    req_valid = '0;
    req_data  = '0;
    @(negedge clk);
    chk("s4 pred_in held", 32'(pred_in[1]), 32'h5A);
    n = 0;
    while (!rsp_valid[1] && n < 20) begin @(negedge clk); n++; end
    chk("s4 latency", 32'(n), 32'd4);
    chk("s4 rsp_data", 32'(rsp_data[1]), 32'h1);
    chk("s4 pred_in still", 32'(pred_in[1]), 32'h5A);
    drain();

    // Saturation via backdoor preload
    force g_dut[0].u_dut.hit_count = 16'hFFFE;
    g_dut[0].m_hits = 16'hFFFE;
    step();
    release g_dut[0].u_dut.hit_count;
    req_valid = 4'b0001;
    req_data  = {24'h0, 8'h5A};
    repeat (9) step();
    drain();
    @(negedge clk);
    chk("sat hit_count", 32'(hit_count[0]), 32'hFFFF);

    // Clear together with a hit handshake
    step();
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    req_data  = {24'h0, 8'h5A};
    step();
    req_valid = '0;
    n = 0;
    @(negedge clk);
    while (!rsp_valid[0] && n < 10) begin @(negedge clk); n++; end
    chk("clr reached RESP", 32'(rsp_valid[0]), 32'h1);
    step();
    rsp_ready = 1'b1;
    cnt_clr   = 1'b1;
    step();
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr wins", 32'(hit_count[0]), 32'h0);
    chk("clr handshake done", 32'(rsp_valid[0]), 32'h0);
    drain();

    // Async reset during SETTLE, then requester 0 beats requester 3
    req_valid = 4'b0100;
    req_data  = {$urandom, $urandom};
    step();
    req_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("areset busy0", 32'(busy[0]), 32'h0);
    chk("areset busy1", 32'(busy[1]), 32'h0);
    chk("areset rsp_valid", 32'(rsp_valid), 32'h0);
    step();
    rst_n = 1'b1;
    req_valid = 4'b1001;
    @(negedge clk);
    chk("areset grant0 i0", 32'(req_ready[0]), 32'h1);
    chk("areset grant0 i1", 32'(req_ready[1]), 32'h1);
    step();
    req_valid = '0;
    drain();

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++)
        req_data[i*W +: W] = ($urandom_range(0, 3) == 0) ? 8'h5A : 8'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      cnt_clr   = ($urandom_range(0, 49) == 0);
      step();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
